// File: rtl/benes_cfg_loader_pkg.sv
// Shared constants and FSM state type for the Benes configuration loader.
package USER_PKG;
  localparam int unsigned SWITCH_NUM = 16;
  localparam int unsigned STAGE_NUM  = 9;
  localparam int unsigned IDX_W      = $clog2(STAGE_NUM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FULL
  } cfg_state_t;
endpackage

// File: rtl/benes_cfg_loader_cfg_bank.sv
// STAGE_NUM x SWITCH_NUM register bank: clear, parallel load, or single-stage write.
module cfg_bank
  import USER_PKG::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [SWITCH_NUM-1:0] i_wr_data,
  input  logic                  i_load_en,
  input  logic [SWITCH_NUM-1:0] i_load_data [0:STAGE_NUM-1],
  output logic [SWITCH_NUM-1:0] o_data      [0:STAGE_NUM-1]
);

  logic [SWITCH_NUM-1:0] bank_q [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] bank_d [0:STAGE_NUM-1];

  always_comb begin
    bank_d = bank_q;
    if (i_clr) begin
      bank_d = '{default: '0};
    end else if (i_load_en) begin
      bank_d = i_load_data;
    end else if (i_wr_en) begin
      for (int unsigned k = 0; k < STAGE_NUM; k++) begin
        if (i_wr_idx == IDX_W'(k)) bank_d[k] = i_wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= '{default: '0};
    else        bank_q <= bank_d;
  end

  assign o_data = bank_q;

endmodule

// File: rtl/benes_cfg_loader.sv
// Streams per-stage switch settings into a shadow bank and commits them to the
// active bank that drives the Benes network.
module benes_cfg_loader
  import USER_PKG::*;
#(
  parameter int unsigned EPOCH_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [SWITCH_NUM-1:0] i_cfg_data,
  input  logic                  i_cfg_last,
  input  logic                  i_apply,
  input  logic                  i_flush,
  output logic [SWITCH_NUM-1:0] o_switch_set [0:STAGE_NUM-1],
  output logic                  o_cfg_valid,
  output logic                  o_apply_done,
  output logic                  o_err,
  output logic [EPOCH_W-1:0]    o_epoch
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGE_NUM - 1);

  cfg_state_t          state_q, state_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                apply_done_q, apply_done_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;

  logic                  accept;
  logic                  sh_wr_en;
  logic                  sh_clr;
  logic                  act_load;
  logic [SWITCH_NUM-1:0] shadow_data [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] zero_bank   [0:STAGE_NUM-1];

  assign zero_bank = '{default: '0};
  assign accept    = i_cfg_valid && ready_q;

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    err_d        = 1'b0;
    apply_done_d = 1'b0;
    cfg_valid_d  = cfg_valid_q;
    epoch_d      = epoch_q;
    sh_wr_en     = 1'b0;
    sh_clr       = 1'b0;
    act_load     = 1'b0;

    // Flush outranks everything, including a word or an apply in the same cycle.
    if (i_flush) begin
      state_d  = ST_IDLE;
      wr_idx_d = '0;
      sh_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            if (i_cfg_last && wr_idx_q == LAST_IDX) begin
              sh_wr_en = 1'b1;
              wr_idx_d = wr_idx_q + IDX_W'(1);
              state_d  = ST_FULL;
            end else if (i_cfg_last) begin
              err_d    = 1'b1;
              sh_clr   = 1'b1;
              wr_idx_d = '0;
              state_d  = ST_IDLE;
            end else if (wr_idx_q == LAST_IDX) begin
              err_d    = 1'b1;
              state_d  = ST_DRAIN;
            end else begin
              sh_wr_en = 1'b1;
              wr_idx_d = wr_idx_q + IDX_W'(1);
              state_d  = ST_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && i_cfg_last) begin
            sh_clr   = 1'b1;
            wr_idx_d = '0;
            state_d  = ST_IDLE;
          end
        end
        ST_FULL: begin
          if (i_apply) begin
            act_load     = 1'b1;
            cfg_valid_d  = 1'b1;
            epoch_d      = epoch_q + EPOCH_W'(1);
            apply_done_d = 1'b1;
            wr_idx_d     = '0;
            state_d      = ST_IDLE;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          wr_idx_d = '0;
        end
      endcase
    end

    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_idx_q     <= '0;
      ready_q      <= 1'b1;
      err_q        <= 1'b0;
      apply_done_q <= 1'b0;
      cfg_valid_q  <= 1'b0;
      epoch_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      apply_done_q <= apply_done_d;
      cfg_valid_q  <= cfg_valid_d;
      epoch_q      <= epoch_d;
    end
  end

  cfg_bank u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (sh_clr),
    .i_wr_en     (sh_wr_en),
    .i_wr_idx    (wr_idx_q),
    .i_wr_data   (i_cfg_data),
    .i_load_en   (1'b0),
    .i_load_data (zero_bank),
    .o_data      (shadow_data)
  );

  cfg_bank u_active (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (1'b0),
    .i_wr_en     (1'b0),
    .i_wr_idx    ('0),
    .i_wr_data   ('0),
    .i_load_en   (act_load),
    .i_load_data (shadow_data),
    .o_data      (o_switch_set)
  );

  assign o_cfg_ready  = ready_q;
  assign o_err        = err_q;
  assign o_apply_done = apply_done_q;
  assign o_cfg_valid  = cfg_valid_q;
  assign o_epoch      = epoch_q;

endmodule

// File: doc/benes_cfg_loader.md
BENES_CFG_LOADER -- requirements
Module: benes_cfg_loader

Interface
REQ-001 Parameters SHALL come from USER_PKG: SWITCH_NUM (16, switches per stage), STAGE_NUM (9, Benes stages for SIZE=32); EPOCH_W, default 8, SHALL be the width of the configuration epoch counter.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 i_cfg_valid  in  1  config word valid.
REQ-005 o_cfg_ready  out  1  loader accepts a word this cycle.
REQ-006 i_cfg_data  in  SWITCH_NUM  one stage's switch settings (bit i = switch i; 0 bar, 1 cross).
REQ-007 i_cfg_last  in  1  marks final word of a configuration.
REQ-008 i_apply  in  1  pulse: commit shadow bank to active bank.
REQ-009 i_flush  in  1  pulse: discard shadow bank contents.
REQ-010 o_switch_set  out  SWITCH_NUM x [0:STAGE_NUM-1]  active per-stage settings, drives the network switch_set input.
REQ-011 o_cfg_valid  out  1  active bank holds a committed configuration.
REQ-012 o_apply_done  out  1  one-cycle pulse on commit.
REQ-013 o_err  out  1  one-cycle pulse on framing error.
REQ-014 o_epoch  out  EPOCH_W  count of commits, wraps modulo 2^EPOCH_W.

Function
REQ-015 Handshake: a word SHALL transfer when i_cfg_valid && o_cfg_ready on a clock edge; the data SHALL be written to shadow[wr_idx], and wr_idx SHALL increment.
REQ-016 FSM states SHALL be IDLE, LOAD, DRAIN and FULL; o_cfg_ready SHALL be 1 in IDLE, LOAD and DRAIN, and 0 in FULL.
REQ-017 IDLE: on the first accepted word the FSM SHALL go to LOAD, with wr_idx=1.
REQ-018 Accepted word with i_cfg_last=1 and wr_idx==STAGE_NUM-1: the FSM SHALL go to FULL.
REQ-019 Accepted word with i_cfg_last=1 and wr_idx<STAGE_NUM-1 (short frame): o_err SHALL pulse, the shadow SHALL be discarded, wr_idx SHALL be set to 0, and the FSM SHALL go to IDLE.
REQ-020 Accepted word with i_cfg_last=0 and wr_idx==STAGE_NUM-1 (long frame): o_err SHALL pulse and the FSM SHALL go to DRAIN.
REQ-021 DRAIN: the loader SHALL accept and drop words; on an accepted word with last=1 it SHALL go to IDLE with wr_idx=0.
REQ-022 FULL + i_apply: on the same edge, the active bank SHALL be loaded from shadow, o_cfg_valid SHALL be set to 1, and o_epoch SHALL increment; o_apply_done SHALL pulse in the following cycle, with o_switch_set updated in that same cycle; the FSM SHALL go to IDLE.
REQ-023 i_apply outside FULL SHALL be ignored, with no error raised.
REQ-024 i_flush in any state SHALL return the FSM to IDLE with wr_idx=0; the active bank and o_cfg_valid SHALL be unaffected.
REQ-025 i_flush and i_apply asserted in the same cycle: flush SHALL win, and no commit SHALL occur.
REQ-026 i_flush and an accepted word in the same cycle: the word SHALL be dropped.
REQ-027 o_switch_set SHALL be driven directly from the active-bank flops (no combinational path from inputs), and SHALL change only on a commit.
REQ-028 Once set, o_cfg_valid SHALL remain 1 until reset.
REQ-029 o_epoch SHALL wrap from 2^EPOCH_W-1 to 0 without error.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately, asynchronously, put: FSM in IDLE, wr_idx 0, shadow and active banks all-zero (identity permutation), o_cfg_valid 0, o_apply_done 0, o_err 0, o_epoch 0, o_cfg_ready 1.
REQ-031 Reset during LOAD or FULL SHALL discard the partial or pending configuration, and no commit pulse SHALL follow.

Structure
REQ-032 SWITCH_NUM, STAGE_NUM and a cfg_state_t enum SHALL reside in USER_PKG; the stage-index width SHALL be $clog2(STAGE_NUM).
REQ-033 One sub-module SHALL exist: cfg_bank, a STAGE_NUM x SWITCH_NUM register array with a write-enable/index port and a parallel load port; it SHALL be instantiated twice (shadow and active).

Verification
REQ-034 Load 9 words 16'h0001..16'h0009, last on the 9th, then i_apply -> o_apply_done pulses once, o_switch_set[k]=k+1, o_cfg_valid=1, o_epoch=1.
REQ-035 Hold i_cfg_valid high through FULL -> o_cfg_ready=0, and no word is lost or overwritten until after apply.
REQ-036 Short frame: last on word 4 -> o_err pulses, the FSM is back in IDLE, the active bank is unchanged, and a following valid 9-word frame commits correctly.
REQ-037 Long frame: 12 words, last on the 12th -> o_err pulses at word 9, words 10-12 are dropped, and apply afterwards is ignored.
REQ-038 FULL with i_flush and i_apply in the same cycle -> no o_apply_done, o_epoch unchanged, o_cfg_ready=1 next cycle.
REQ-039 256 successive commits -> o_epoch wraps to 0; async rst_n pulse mid-LOAD -> all outputs at reset values within the same cycle.
